// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: operation
// encodings, default latencies, FSM state type and small op-class helpers.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_DIV   = 4'd2,
    MDU_MTHI  = 4'd3,
    MDU_MTLO  = 4'd4,
    MDU_MULTU = 4'd5,
    MDU_DIVU  = 4'd6
  } mdu_op_e;

  // Default busy durations; the down-counter is 4 bits, so both must stay below 16.
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam int unsigned CNT_W           = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

  // True for the four multi-cycle operations that start may launch.
  function automatic logic is_launch_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  function automatic logic is_mult_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage : mdu_pkg

// File: rtl/mdu_calc.sv
// Combinational arithmetic core of the MDU. Works only on the operands and
// op latched at launch; produces the 64-bit {hi,lo} result and flags a
// division by zero so the caller can skip the commit.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic signed [63:0] a_sext;
  logic signed [63:0] b_sext;
  logic        [63:0] a_zext;
  logic        [63:0] b_zext;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] b_safe;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quot_u;
  logic        [31:0] rem_u;
  logic               div_ovf;

  // Widen operands so the products are computed at full 64-bit precision.
  assign a_sext = {{32{a[31]}}, a};
  assign b_sext = {{32{b[31]}}, b};
  assign a_zext = {32'd0, a};
  assign b_zext = {32'd0, b};
  assign prod_s = a_sext * b_sext;
  assign prod_u = a_zext * b_zext;

  // A zero divisor is replaced by 1 so the divider never sees an undefined
  // case; the result is discarded anyway because div_by_zero blocks the commit.
  assign b_safe  = (b == 32'd0) ? 32'd1 : b;
  assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  // Signed and unsigned quotient/remainder; SV division truncates toward zero
  // and gives the remainder the sign of the dividend, matching MIPS div.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    quot_s = $signed(a) / $signed(b_safe);
    rem_s  = $signed(a) % $signed(b_safe);
    if (div_ovf) begin
      quot_s = 32'sh8000_0000;
      rem_s  = 32'sd0;
    end
    quot_u = a / b_safe;
    rem_u  = a % b_safe;
  end

  // Select the result for the latched operation.
  always_comb begin
    result      = 64'd0;
    div_by_zero = is_div_op(op) && (b == 32'd0);
    case (op)
      MDU_MULT:  result = prod_s;
      MDU_MULTU: result = prod_u;
      MDU_DIV:   result = {rem_s, quot_s};
      MDU_DIVU:  result = {rem_u, quot_u};
      default:   result = 64'd0;
    endcase
  end

endmodule : mdu_calc

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit. Owns the HI/LO registers, launches
// mult/multu/div/divu on start and holds busy for MULT_CYCLES or DIV_CYCLES,
// committing {hi,lo} on the last busy edge. mthi/mtlo write in one cycle.
// Optional build macro MDU_ABORT_EN adds an abort input that flushes an
// operation in flight and suppresses a same-cycle launch or move.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  mdu_op,
`ifdef MDU_ABORT_EN
  input  logic        abort,
`endif
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, b_q;
  logic [3:0]       op_q;
  logic [31:0]      hi_q, lo_q;

  logic             flush;
  logic             launch;
  logic             commit;
  logic             wr_hi;
  logic             wr_lo;
  logic [63:0]      calc_result;
  logic             calc_div_by_zero;

`ifdef MDU_ABORT_EN
  assign flush = abort;
`else
  assign flush = 1'b0;
`endif

  mdu_calc u_calc (
    .a           (a_q),
    .b           (b_q),
    .op          (op_q),
    .result      (calc_result),
    .div_by_zero (calc_div_by_zero)
  );

  // State and counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: launch/move decode in IDLE, countdown and commit in BUSY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    launch  = 1'b0;
    commit  = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush) begin
          if (start && is_launch_op(mdu_op)) begin
            launch  = 1'b1;
            state_d = BUSY;
            cnt_d   = is_mult_op(mdu_op) ? MULT_LOAD : DIV_LOAD;
          end else if (!start && (mdu_op == MDU_MTHI)) begin
            wr_hi = 1'b1;
          end else if (!start && (mdu_op == MDU_MTLO)) begin
            wr_lo = 1'b1;
          end
        end
      end
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            commit  = !calc_div_by_zero;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Operand/op latch: results depend only on values captured at launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= MDU_NONE;
    end else if (launch) begin
      a_q  <= src_a;
      b_q  <= src_b;
      op_q <= mdu_op;
    end
  end

  // HI/LO architectural registers: full commit or single-register move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit) begin
      hi_q <= calc_result[63:32];
      lo_q <= calc_result[31:0];
    end else begin
      if (wr_hi) hi_q <= src_a;
      if (wr_lo) lo_q <= src_a;
    end
  end

  assign busy = (state_q == BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule : mdu_unit

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Consumes the controller's start and MDU_OP outputs together with the forwarded rs/rt operands.
- Owns the HI/LO architectural registers and models multi-cycle latency with a busy signal.
- The hazard unit stalls any MDU-class instruction in D while busy or start is high.
- Values read by mfhi/mflo go to the E-stage result mux.

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu.
- DIV_CYCLES, 10, busy duration for div/divu.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  launch mult/multu/div/divu this cycle.
- mdu_op  input  4  1=mult, 2=div, 3=mthi, 4=mtlo, 5=multu, 6=divu, 0=none.
- src_a  input  32  rs operand, already forwarded.
- src_b  input  32  rt operand, already forwarded.
- busy  output  1  operation in progress.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset: asynchronous on rst_n low. busy=0, hi=0, lo=0, internal counter=0, state=IDLE.
- States: IDLE and BUSY. The internal counter is 4 bits wide.
- IDLE, start=1 with mdu_op in {1,2,5,6}:
  - Latch src_a, src_b and mdu_op.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Go to BUSY; busy rises at the next edge.
- BUSY: decrement the counter every cycle.
  - When the counter is 1, commit the result to hi/lo at that edge and go to IDLE.
  - busy is therefore high for exactly N cycles.
  - New hi/lo values are visible in the first cycle busy is low.
- mthi (op 3) / mtlo (op 4) with start=0 in IDLE: hi (or lo) <= src_a at the next edge. Single-cycle, busy stays 0.
- Arithmetic:
  - mult: signed 32x32 -> 64, {hi,lo}=product.
  - multu: unsigned 32x32 -> 64, {hi,lo}=product.
  - div: signed, lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - All results come from the latched operands, never the live ports.
- Division by zero: full DIV_CYCLES are consumed; hi/lo are left unchanged.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Illegal or ignored inputs:
  - start=1 with mdu_op in {0,3,4}: ignored.
  - start or mthi/mtlo while BUSY: ignored; the bench flags this as a protocol error.
  - mdu_op in {1,2,5,6} with start=0: no effect.
- hi and lo are plain registers; the read path adds no extra latency.

Optional Feature:
- Macro: MDU_ABORT_EN.
- Defined: adds input port abort (1 bit) for the exception flush in a later pipeline revision.
  - abort=1 in BUSY: go to IDLE at the next edge, busy=0, hi/lo unchanged, no commit.
  - abort=1 in the same cycle as start: the launch is suppressed.
  - abort=1 in the same cycle as mthi/mtlo: the write is suppressed.
  - abort=1 in IDLE: no effect.
- Not defined: no abort port; every operation runs to completion.

Decomposition:
- Package mdu_pkg:
  - Op encodings: MDU_NONE=0, MDU_MULT=1, MDU_DIV=2, MDU_MTHI=3, MDU_MTLO=4, MDU_MULTU=5, MDU_DIVU=6.
  - Default latency constants.
  - State enum: IDLE, BUSY.
- Sub-module mdu_calc: combinational; latched operands and op in, 64-bit {hi,lo} result plus a div_by_zero flag out.
- mdu_unit holds the FSM, counter and registers.

Test Plan:
- Reset then idle: rst_n low mid-cycle -> hi=lo=0 and busy=0 immediately, without waiting for a clock edge.
- mult -3 x 5 (src_a=0xFFFFFFFD, src_b=5): start at cycle 0 -> busy high cycles 1-5; cycle 6 shows hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- multu 0xFFFFFFFF x 2 -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE. Change src_a/src_b during BUSY -> result unaffected.
- div -7/2 -> busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/0 with prior hi=0x11, lo=0x22 -> after 10 cycles hi=0x11, lo=0x22.
- mthi src_a=0x1234 then mtlo src_a=0x5678 on consecutive cycles -> hi=0x1234, lo=0x5678, busy never asserted. mthi attempted during a div -> ignored, hi reflects the div result.
- MDU_ABORT_EN build: start div, assert abort at busy cycle 4 -> busy=0 next cycle, hi/lo hold their prior values. A following mult completes normally.
